// File: rtl/tcdm_port_arbiter.sv
// Shares one MP-lane TCDM port between a wide streamer port and a narrow
// 32-bit core port. Requests are arbitrated combinationally. Accepted
// transactions are tracked in an in-order FIFO so that each response is
// routed back to the port that issued it.
module tcdm_port_arbiter #(
  parameter int unsigned MP          = 4,
  parameter int unsigned MAX_STALL   = 8,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  // narrow (core) port
  input  logic                           n_req_i,
  output logic                           n_gnt_o,
  input  logic [31:0]                    n_add_i,
  input  logic                           n_wen_i,
  input  logic [3:0]                     n_be_i,
  input  logic [31:0]                    n_data_i,
  output logic [31:0]                    n_r_data_o,
  output logic                           n_r_valid_o,
  // wide (streamer) port
  input  logic                           w_req_i,
  output logic                           w_gnt_o,
  input  logic [31:0]                    w_add_i,
  input  logic                           w_wen_i,
  input  logic [MP*4-1:0]                w_be_i,
  input  logic [MP*32-1:0]               w_data_i,
  output logic [MP*32-1:0]               w_r_data_o,
  output logic                           w_r_valid_o,
  // memory port
  output logic                           m_req_o,
  input  logic                           m_gnt_i,
  output logic [31:0]                    m_add_o,
  output logic                           m_wen_o,
  output logic [MP*4-1:0]                m_be_o,
  output logic [MP*32-1:0]               m_data_o,
  input  logic [MP*32-1:0]               m_r_data_i,
  input  logic                           m_r_valid_i,
  // status
  output logic [$clog2(MAX_STALL+1)-1:0] stall_cnt_o,
  output logic                           err_o
);

  localparam int unsigned LW = $clog2(MP);
  localparam int unsigned SW = $clog2(MAX_STALL + 1);
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  typedef struct packed {
    logic          owner_n;  // 1: narrow port owns the response
    logic [LW-1:0] lane;     // lane holding the narrow read data
  } entry_t;

  entry_t        fifo_q [OUTSTANDING];
  entry_t        head;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  logic          fifo_full, fifo_empty, fifo_block;
  logic          sel_n, push, pop;
  logic [LW-1:0] lane;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^n_add_i[1:0];

  assign lane       = n_add_i[LW+1:2];
  assign fifo_full  = (cnt_q == CW'(OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  // A response in the same cycle frees a slot, so a full FIFO only blocks
  // when nothing is being popped.
  assign fifo_block = fifo_full & ~m_r_valid_i;

  // Wide wins unless it is idle or the narrow port has starved long enough.
  assign sel_n   = ~w_req_i | (stall_q == SW'(MAX_STALL));
  assign m_req_o = (n_req_i | w_req_i) & ~fifo_block;
  assign push    = m_req_o & m_gnt_i;
  assign pop     = m_r_valid_i & ~fifo_empty;
  assign n_gnt_o = push & sel_n;
  assign w_gnt_o = push & ~sel_n;

  // Request mux: narrow accesses are lane-packed, wide ones pass through.
  always_comb begin
    m_add_o  = w_add_i;
    m_wen_o  = w_wen_i;
    m_be_o   = w_be_i;
    m_data_o = w_data_i;
    if (sel_n) begin
      m_add_o                    = {n_add_i[31:LW+2], {(LW+2){1'b0}}};
      m_wen_o                    = n_wen_i;
      m_be_o                     = '0;
      m_be_o[{lane, 2'b00} +: 4] = n_be_i;
      m_data_o                   = {MP{n_data_i}};
    end
  end

  // Response routing from the FIFO head; unowned responses are dropped.
  always_comb begin
    head        = fifo_q[rd_ptr_q];
    n_r_valid_o = pop & head.owner_n;
    w_r_valid_o = pop & ~head.owner_n;
    n_r_data_o  = m_r_data_i[{head.lane, 5'b00000} +: 32];
    w_r_data_o  = m_r_data_i;
  end

  // Next-state for FIFO pointers, occupancy, starvation counter and error flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    stall_d  = stall_q;
    err_d    = err_q | (m_r_valid_i & fifo_empty);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (!n_req_i || n_gnt_o) begin
      stall_d = '0;
    end else if (stall_q != SW'(MAX_STALL)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // Tracking FIFO storage; contents are only meaningful below cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{owner_n: sel_n, lane: lane};
    end
  end

  assign stall_cnt_o = stall_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// Bench for tcdm_port_arbiter: directed scenarios plus a random phase.
// A reference model predicts grants/muxing and queues expected owners;
// a monitor pops that queue whenever memory returns a response.
module tb_tcdm_port_arbiter;
  localparam int MP          = 4;
  localparam int MAX_STALL   = 8;
  localparam int OUTSTANDING = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic n_req, n_wen, n_gnt_o, n_r_valid_o;
  logic [31:0] n_add, n_data, n_r_data_o;
  logic [3:0] n_be;
  logic w_req, w_wen, w_gnt_o, w_r_valid_o;
  logic [31:0] w_add;
  logic [MP*4-1:0] w_be;
  logic [MP*32-1:0] w_data, w_r_data_o;
  logic m_req_o, m_gnt, m_wen_o, m_r_valid;
  logic [31:0] m_add_o;
  logic [MP*4-1:0] m_be_o;
  logic [MP*32-1:0] m_data_o, m_r_data;
  logic [$clog2(MAX_STALL+1)-1:0] stall_cnt_o;
  logic err_o;

  tcdm_port_arbiter #(.MP(MP), .MAX_STALL(MAX_STALL), .OUTSTANDING(OUTSTANDING)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .n_req_i(n_req), .n_gnt_o(n_gnt_o), .n_add_i(n_add), .n_wen_i(n_wen),
    .n_be_i(n_be), .n_data_i(n_data), .n_r_data_o(n_r_data_o), .n_r_valid_o(n_r_valid_o),
    .w_req_i(w_req), .w_gnt_o(w_gnt_o), .w_add_i(w_add), .w_wen_i(w_wen),
    .w_be_i(w_be), .w_data_i(w_data), .w_r_data_o(w_r_data_o), .w_r_valid_o(w_r_valid_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
    .m_be_o(m_be_o), .m_data_o(m_data_o), .m_r_data_i(m_r_data), .m_r_valid_i(m_r_valid),
    .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model state ----------------
  typedef struct { bit owner_n; int lane; } exp_t;
  exp_t exp_q[$];
  int   mem_q[$];
  int   m_out = 0;
  int   m_stall = 0;
  bit   m_err = 0;
  bit   last_ngnt = 0;
  bit   last_wgnt = 0;
  bit   mem_auto = 0;
  int   dly_min = 1;
  int   dly_max = 1;
  int   cyc = 0;

  // Reference model: arbitration, packing and bookkeeping from the rules.
  always @(negedge clk) begin
    bit sel_n, mreq, acc, ngnt, wgnt;
    int lane;
    logic [15:0] eb;
    sel_n = !w_req || (m_stall == MAX_STALL);
    mreq  = (n_req || w_req) && !((m_out == OUTSTANDING) && !m_r_valid);
    acc   = mreq && m_gnt;
    ngnt  = acc && sel_n;
    wgnt  = acc && !sel_n;
    lane  = int'(n_add[31:2]) % MP;
    eb    = 16'(n_be) << (4 * lane);

    check("m_req_o", m_req_o, mreq);
    check("n_gnt_o", n_gnt_o, ngnt);
    check("w_gnt_o", w_gnt_o, wgnt);
    check("stall_cnt_o", stall_cnt_o, m_stall);
    check("err_o", err_o, m_err);
    if (mreq) begin
      if (sel_n) begin
        check("narrow m_add_o", m_add_o, n_add & ~32'(MP*4-1));
        check("narrow m_be_o", m_be_o, eb);
        check("narrow m_data_o", m_data_o, {MP{n_data}});
        check("narrow m_wen_o", m_wen_o, n_wen);
      end else begin
        check("wide m_add_o", m_add_o, w_add);
        check("wide m_be_o", m_be_o, w_be);
        check("wide m_data_o", m_data_o, w_data);
        check("wide m_wen_o", m_wen_o, w_wen);
      end
    end
    last_ngnt = ngnt;
    last_wgnt = wgnt;

    if (m_r_valid) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
    if (acc) begin
      m_out++;
      exp_q.push_back('{sel_n, sel_n ? lane : 0});
      if (mem_auto) mem_q.push_back(cyc + int'($urandom_range(dly_max, dly_min)));
    end
    if (!n_req || ngnt) m_stall = 0;
    else if (m_stall < MAX_STALL) m_stall++;

    if (!rst_n) begin
      m_out = 0; m_stall = 0; m_err = 0;
      exp_q.delete();
      mem_q.delete();
    end
  end

  // Response monitor: pops the expected owner on every memory response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (m_r_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.owner_n) begin
          check("resp n_r_valid_o", n_r_valid_o, 1);
          check("resp w_r_valid_o", w_r_valid_o, 0);
          check("resp n_r_data_o", n_r_data_o, m_r_data[e.lane*32 +: 32]);
        end else begin
          check("resp w_r_valid_o", w_r_valid_o, 1);
          check("resp n_r_valid_o", n_r_valid_o, 0);
          check("resp w_r_data_o", w_r_data_o, m_r_data);
        end
      end else begin
        check("idle n_r_valid_o", n_r_valid_o, 0);
        check("idle w_r_valid_o", w_r_valid_o, 0);
      end
    end
  end

  // Memory model: in-order responses after the scheduled delay.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (mem_auto) begin
      m_r_data = {$urandom, $urandom, $urandom, $urandom};
      if (mem_q.size() > 0 && mem_q[0] <= cyc) begin
        m_r_valid = 1'b1;
        void'(mem_q.pop_front());
      end else begin
        m_r_valid = 1'b0;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      next();
      k++;
    end
    check("drain outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rd;
    rst_n = 0; n_req = 0; n_wen = 1; n_add = 0; n_be = 0; n_data = 0;
    w_req = 0; w_wen = 1; w_add = 0; w_be = 0; w_data = 0;
    m_gnt = 0; m_r_valid = 0; m_r_data = 0;
    next(); next();
    @(negedge clk);
    check("reset err_o", err_o, 0);
    check("reset stall_cnt_o", stall_cnt_o, 0);
    check("reset n_r_valid_o", n_r_valid_o, 0);
    check("reset w_r_valid_o", w_r_valid_o, 0);
    next();
    rst_n = 1;
    next();

    // narrow read into lane 3
    n_req = 1; n_add = 32'h1C01000C; n_wen = 1; n_be = 4'hF; n_data = 32'hCAFE0123; m_gnt = 1;
    @(negedge clk);
    check("nr m_add_o", m_add_o, 32'h1C010000);
    check("nr m_be_o", m_be_o, 16'hF000);
    check("nr n_gnt_o", n_gnt_o, 1);
    next();
    n_req = 0; m_r_valid = 1;
    m_r_data = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    @(negedge clk);
    check("nr n_r_valid_o", n_r_valid_o, 1);
    check("nr n_r_data_o", n_r_data_o, 32'hD3D3D3D3);
    check("nr w_r_valid_o", w_r_valid_o, 0);
    next();
    m_r_valid = 0;

    // starvation: wide wins 8 times, then narrow is forced through
    mem_auto = 1; dly_min = 1; dly_max = 1;
    w_req = 1; w_add = 32'h1C020000; w_be = '1; w_wen = 0;
    w_data = {$urandom, $urandom, $urandom, $urandom};
    n_req = 1; n_add = 32'h1C010004; n_be = 4'h3; n_wen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("starve w_gnt_o", w_gnt_o, (i != 8));
      check("starve n_gnt_o", n_gnt_o, (i == 8));
      check("starve stall_cnt_o", stall_cnt_o, (i <= 8) ? i : 0);
      next();
    end
    n_req = 0; w_req = 0;
    drain();

    // FIFO full blocks until a response frees a slot
    mem_auto = 0; m_r_valid = 0; w_req = 1; w_wen = 1;
    @(negedge clk); check("blk accept0", w_gnt_o, 1); next();
    @(negedge clk); check("blk accept1", w_gnt_o, 1); next();
    @(negedge clk); check("blk full m_req_o", m_req_o, 0); next();
    m_r_valid = 1; m_r_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    check("blk pop+push m_req_o", m_req_o, 1);
    check("blk pop+push w_gnt_o", w_gnt_o, 1);
    next();
    w_req = 0; m_r_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); next();
    m_r_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); next();
    m_r_valid = 0;

    // interleaved wide, narrow (lane 2), wide
    w_req = 1; w_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); check("il w accept", w_gnt_o, 1); next();
    w_req = 0; n_req = 1; n_add = 32'h1C030008; n_be = 4'hF; n_wen = 1;
    @(negedge clk); check("il n accept", n_gnt_o, 1); next();
    n_req = 0; w_req = 1; m_r_valid = 1;
    rd = {$urandom, $urandom, $urandom, $urandom}; m_r_data = rd;
    @(negedge clk);
    check("il resp0 w_r_valid_o", w_r_valid_o, 1);
    check("il w accept2", w_gnt_o, 1);
    next();
    w_req = 0; rd = {$urandom, $urandom, $urandom, $urandom}; m_r_data = rd;
    @(negedge clk);
    check("il resp1 n_r_valid_o", n_r_valid_o, 1);
    check("il resp1 n_r_data_o", n_r_data_o, rd[95:64]);
    check("il resp1 w_r_valid_o", w_r_valid_o, 0);
    next();
    rd = {$urandom, $urandom, $urandom, $urandom}; m_r_data = rd;
    @(negedge clk);
    check("il resp2 w_r_valid_o", w_r_valid_o, 1);
    check("il resp2 w_r_data_o", w_r_data_o, rd);
    next();
    m_r_valid = 0;

    // response with nothing outstanding
    m_r_valid = 1;
    @(negedge clk);
    check("orphan n_r_valid_o", n_r_valid_o, 0);
    check("orphan w_r_valid_o", w_r_valid_o, 0);
    next();
    m_r_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("orphan err sticky", err_o, 1); next();
    end
    rst_n = 0;
    next();
    rst_n = 1;
    @(negedge clk); check("err cleared by reset", err_o, 0); next();

    // reset with two transactions in flight
    w_req = 1;
    @(negedge clk); next();
    @(negedge clk); next();
    w_req = 0; rst_n = 0;
    next();
    rst_n = 1;
    @(negedge clk);
    check("post-rst stall_cnt_o", stall_cnt_o, 0);
    check("post-rst err_o", err_o, 0);
    next();
    m_r_valid = 1;
    @(negedge clk);
    check("late n_r_valid_o", n_r_valid_o, 0);
    check("late w_r_valid_o", w_r_valid_o, 0);
    next();
    m_r_valid = 0;
    @(negedge clk); check("late err_o", err_o, 1); next();
    w_req = 1;
    @(negedge clk); check("post-rst fifo empty gnt0", w_gnt_o, 1); next();
    @(negedge clk); check("post-rst fifo empty gnt1", w_gnt_o, 1); next();
    w_req = 0; rst_n = 0;
    next();
    rst_n = 1;
    next();

    // random traffic
    mem_auto = 1; dly_min = 1; dly_max = 4;
    for (int c = 0; c < 3000; c++) begin
      if (!n_req || last_ngnt) begin
        n_req  = ($urandom % 3) != 0;
        n_add  = $urandom;
        n_be   = 4'($urandom);
        n_data = $urandom;
        n_wen  = 1'($urandom);
      end
      if (!w_req || last_wgnt) begin
        w_req  = ($urandom % 4) != 0;
        w_add  = $urandom & ~32'(MP*4-1);
        w_be   = 16'($urandom);
        w_data = {$urandom, $urandom, $urandom, $urandom};
        w_wen  = 1'($urandom);
      end
      m_gnt = ($urandom % 4) != 0;
      next();
    end
    n_req = 0; w_req = 0;
    drain();
    next();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tcdm_port_arbiter.md
Name: tcdm_port_arbiter

Overview:
- Shares one wide TCDM data port (MP x 32-bit lanes) between the accelerator's wide streamer port and the core's narrow 32-bit data port.
- Arbitrates requests, packs the narrow access into its lane, and tracks outstanding transactions in order so each response returns to its requester.
- Sits between the accelerator complex and the data memory in the bench and in the cluster integration.

Parameters:
- MP, 4, number of 32-bit lanes on the wide port (power of 2, >=2).
- MAX_STALL, 8, number of consecutive cycles a pending narrow request may lose arbitration before it is forced through.
- OUTSTANDING, 2, depth of the in-order response-tracking FIFO (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- n_req_i  in  1  narrow request
- n_gnt_o  out  1  narrow grant
- n_add_i  in  32  narrow byte address
- n_wen_i  in  1  narrow write-enable-low (1 = read)
- n_be_i  in  4  narrow byte enables
- n_data_i  in  32  narrow write data
- n_r_data_o  out  32  narrow read data
- n_r_valid_o  out  1  narrow response valid
- w_req_i  in  1  wide request
- w_gnt_o  out  1  wide grant
- w_add_i  in  32  wide byte address, MP*4-aligned
- w_wen_i  in  1  wide write-enable-low
- w_be_i  in  MP*4  wide byte enables
- w_data_i  in  MP*32  wide write data
- w_r_data_o  out  MP*32  wide read data
- w_r_valid_o  out  1  wide response valid
- m_req_o / m_gnt_i  out / in  1 / 1  memory request / grant
- m_add_o  out  32  memory address
- m_wen_o  out  1  memory write-enable-low
- m_be_o  out  MP*4  memory byte enables
- m_data_o  out  MP*32  memory write data
- m_r_data_i  in  MP*32  memory read data
- m_r_valid_i  in  1  memory response valid
- stall_cnt_o  out  $clog2(MAX_STALL+1)  current narrow starvation count
- err_o  out  1  sticky: response received with no outstanding entry

Behaviour:
- Handshake protocol (TCDM):
  - A request is accepted in the cycle where req & gnt.
  - Memory returns exactly one m_r_valid_i per accepted transaction (reads and writes), in order, at least 1 cycle after acceptance.
- Request path: combinational from inputs.
  - m_req_o = (n_req_i | w_req_i) & ~fifo_block.
  - fifo_block = fifo_full & ~m_r_valid_i. A pop and a push in the same cycle are legal when full.
- Selection:
  - Wide wins by default.
  - Narrow wins when w_req_i=0, or when stall_cnt == MAX_STALL (forced).
  - n_gnt_o = m_gnt_i & m_req_o & sel_n; w_gnt_o = m_gnt_i & m_req_o & ~sel_n. Never both high.
- Narrow packing:
  - lane L = n_add_i[$clog2(MP)+1:2].
  - m_add_o = n_add_i with bits [$clog2(MP)+1:0] cleared.
  - m_be_o = n_be_i shifted into lane L, other lanes 0.
  - m_data_o = n_data_i replicated across all lanes.
- Wide request: m_add_o, m_be_o and m_data_o pass through unchanged.
- Starvation counter (stall_cnt):
  - Increments when n_req_i=1 and no narrow grant occurs, saturating at MAX_STALL.
  - Clears on a narrow grant, or when n_req_i=0.
- Tracking FIFO:
  - Each accepted transaction pushes {owner, L}.
  - Each m_r_valid_i pops the head.
  - If head owner = narrow: n_r_valid_o=1 and n_r_data_o = lane L of m_r_data_i.
  - If head owner = wide: w_r_valid_o=1 and w_r_data_o = m_r_data_i.
  - Responses are combinational (same cycle as m_r_valid_i).
- Empty FIFO: m_r_valid_i with FIFO empty drops the response (no r_valid out) and sets err_o. err_o stays high until reset.
- Reset (rst_ni=0 at a clk_i edge):
  - Clears FIFO, stall_cnt and err_o.
  - Outputs during/after reset: all r_valid=0, err_o=0, stall_cnt_o=0. Grants follow the combinational rules.
  - In-flight responses arriving after reset set err_o.
- Rules that hold at all times: while a request is pending, its inputs stay stable until granted. The arbiter keeps no grant-lock state across cycles beyond stall_cnt.

Test Plan:
- Narrow read only, MP=4, n_add_i=0x1C01000C, memory data lanes {D3,D2,D1,D0} -> m_add_o=0x1C010000, m_be_o=0xF000; next-cycle response gives n_r_valid_o=1, n_r_data_o=D3, w_r_valid_o=0.
- Wide and narrow request continuously, m_gnt_i=1, MAX_STALL=8 -> wide granted cycles 0..7, stall_cnt_o counts 1..8, narrow granted cycle 8, stall_cnt_o back to 0, wide granted cycle 9.
- OUTSTANDING=2, m_gnt_i=1, memory delays responses 3 cycles -> after 2 accepts m_req_o=0. In the cycle m_r_valid_i=1, m_req_o=1 and a new grant is issued (pop+push).
- Interleaved wide, narrow, wide accepts -> responses route wide, narrow, wide in order; no cross-routing; narrow data taken from the correct lane.
- m_r_valid_i=1 with no outstanding entries -> no r_valid on either side, err_o=1 and stays 1 until rst_ni=0 for one cycle, then 0.
- Reset asserted with 2 outstanding -> FIFO empty and stall_cnt_o=0 after the edge; a late m_r_valid_i sets err_o and produces no r_valid.
